// File: rtl/serial_fa_sequencer_pkg.sv
// Shared definitions for the bit-serial full-adder sequencer: FSM state encodings
// and a counter-width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package serial_fa_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_shreg.sv
// Operand/result right-shift registers for the serial adder (a, b in; sum out).
// Latency: load and shift take effect on the next rising edge. Backpressure: none, enables only.
// Ports: load_i/op_a_i/op_b_i load operands; shift_i/sum_bit_i shift one bit; *_q current, *_d next.
module serial_fa_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             sum_bit_i,
    output logic [WIDTH-1:0] a_d_o,
    output logic [WIDTH-1:0] b_d_o,
    output logic [WIDTH-1:0] s_d_o,
    output logic [WIDTH-1:0] s_q_o
);

    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic [WIDTH-1:0] a_d, b_d, s_d;
    logic [WIDTH:0]   s_cat;

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign s_cat = {sum_bit_i, s_q} >> 1;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        if (load_i) begin
            a_d = op_a_i;
            b_d = op_b_i;
            s_d = '0;
        end else if (shift_i) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            s_d = s_cat[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign a_d_o = a_d;
    assign b_d_o = b_d;
    assign s_d_o = s_d;
    assign s_q_o = s_q;

endmodule

// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder controller time-sharing one external full-adder cell over WIDTH bits.
// Latency: done pulses WIDTH*SETTLE_CYCLES edges after the accepting edge.
// Backpressure: start accepted only while ready=1; requests while busy are dropped, not queued.
// Ports: start/abort/op_a/op_b/cin request side; ready/done/sum/cout result side;
//        fa_a/fa_b/fa_cin drive the shared cell, fa_sum/fa_cout are sampled back from it.
module serial_fa_sequencer
    import serial_fa_sequencer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int IDX_W = cnt_w(WIDTH);
    localparam int SET_W = cnt_w(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(WIDTH - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic             carry_q;
    logic             ready_q, done_q, cout_q;
    logic             fa_a_q, fa_b_q, fa_cin_q;
    logic [WIDTH-1:0] sum_q;

    logic             load_en, sample_en;
    logic [WIDTH-1:0] a_d, b_d, s_d, s_q;

    // Abort takes priority over a sample falling on the same edge.
    assign load_en   = (state_q == ST_IDLE) && start;
    assign sample_en = (state_q == ST_DRIVE) && !abort && (settle_cnt_q == LAST_SETTLE);

    serial_fa_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_en),
        .shift_i   (sample_en),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .sum_bit_i (fa_sum),
        .a_d_o     (a_d),
        .b_d_o     (b_d),
        .s_d_o     (s_d),
        .s_q_o     (s_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            settle_cnt_q <= '0;
            carry_q      <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            fa_a_q       <= 1'b0;
            fa_b_q       <= 1'b0;
            fa_cin_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_DRIVE;
                        ready_q      <= 1'b0;
                        carry_q      <= cin;
                        bit_idx_q    <= '0;
                        settle_cnt_q <= '0;
                        // Bit 0 goes onto the cell on the accept edge so it
                        // gets the full settle window.
                        fa_a_q       <= a_d[0];
                        fa_b_q       <= b_d[0];
                        fa_cin_q     <= cin;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        fa_a_q   <= 1'b0;
                        fa_b_q   <= 1'b0;
                        fa_cin_q <= 1'b0;
                    end else if (sample_en) begin
                        settle_cnt_q <= '0;
                        carry_q      <= fa_cout;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            sum_q    <= s_d;
                            cout_q   <= fa_cout;
                            fa_a_q   <= 1'b0;
                            fa_b_q   <= 1'b0;
                            fa_cin_q <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            // Next operand bits come from the post-shift value.
                            fa_a_q    <= a_d[0];
                            fa_b_q    <= b_d[0];
                            fa_cin_q  <= fa_cout;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign sum    = sum_q;
    assign cout   = cout_q;
    assign fa_a   = fa_a_q;
    assign fa_b   = fa_b_q;
    assign fa_cin = fa_cin_q;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Bench for serial_fa_sequencer with a delayed AOI-style full-adder cell on fa_*.
// Latency: n/a. Backpressure: requests issued only while ready=1.
module tb_serial_fa_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, cin;
    logic [3:0] op_a, op_b, sum;
    logic       ready, done, cout, fa_a, fa_b, fa_cin;
    wire        fa_sum, fa_cout, fa_x, fa_nc;

    int n_pass  = 0;
    int n_total = 0;

    // Shared full-adder cell with gate delays well inside one clock period.
    assign #1 fa_x    = fa_a ^ fa_b;
    assign #1 fa_sum  = fa_x ^ fa_cin;
    assign #1 fa_nc   = ~((fa_a & fa_b) | (fa_x & fa_cin));
    assign #1 fa_cout = ~fa_nc;

    always #5 clk = ~clk;

    serial_fa_sequencer #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .ready   (ready),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] exp_s;
        logic       exp_c;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one add from IDLE and follow it to completion.
    task automatic run_add(input logic [3:0] a, input logic [3:0] b, input logic ci,
                           input logic [3:0] exp_s, input logic exp_c, input string tag);
        int lat;
        bit got;
        start = 1'b1; op_a = a; op_b = b; cin = ci;
        step();
        start = 1'b0;
        op_a = 4'($urandom); op_b = 4'($urandom); cin = 1'($urandom);
        chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        chk({tag, "_fa_a_bit0"}, 32'(fa_a), 32'(a[0]));
        chk({tag, "_fa_b_bit0"}, 32'(fa_b), 32'(b[0]));
        chk({tag, "_fa_cin0"}, 32'(fa_cin), 32'(ci));
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            step();
            if (done) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_latency"}, 32'(lat), 32'd8);
            chk({tag, "_sum"}, 32'(sum), 32'(exp_s));
            chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
            step();
            chk({tag, "_ready_back"}, 32'(ready), 32'd1);
            chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        logic [4:0] tot;

        // a, b, cin, sum, cout (hand-computed)
        vecs[0] = '{4'h7, 4'h9, 1'b0, 4'h0, 1'b1};
        vecs[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        vecs[2] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
        vecs[3] = '{4'h5, 4'h6, 1'b1, 4'hC, 1'b0};
        vecs[4] = '{4'hA, 4'h7, 1'b1, 4'h2, 1'b1};
        vecs[5] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        op_a = 4'h0; op_b = 4'h0; cin = 1'b0;
        repeat (2) step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++)
            run_add(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_s, vecs[i].exp_c,
                    $sformatf("vec%0d", i));

        // Starts at edges 3 and 8 of a running add must be dropped.
        start = 1'b1; op_a = 4'h1; op_b = 4'h1; cin = 1'b0;
        step();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            start = (i == 2 || i == 7);
            if (done) ndone++;
        end
        start = 1'b0;
        chk("busy_start_single_done", 32'(ndone), 32'd1);
        chk("busy_start_sum", 32'(sum), 32'd2);
        chk("busy_start_ready", 32'(ready), 32'd1);

        // Abort at edge 4 of 5+6: previous result must survive.
        run_add(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, "pre_abort");
        start = 1'b1; op_a = 4'h5; op_b = 4'h6; cin = 1'b0;
        step();
        start = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        chk("abort_sum_hold", 32'(sum), 32'd7);
        chk("abort_cout_hold", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Asynchronous reset in the middle of an add.
        start = 1'b1; op_a = 4'h9; op_b = 4'h9; cin = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_add(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, "post_reset");

        // Back-to-back sweep of every operand combination.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    tot = 5'(a) + 5'(b) + 5'(c);
                    run_add(4'(a), 4'(b), 1'(c), tot[3:0], tot[4],
                            $sformatf("sweep_%0h_%0h_%0d", a, b, c));
                end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
